// File: rtl/div_seq_if.sv
// Handshake/bus bundle for the sequential RV32M divider.
// master: the ex-stage side that issues divides; slave: the divider itself.
interface div_seq_if #(
  parameter int XLEN = 32
) ();
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      reg_waddr_i;
  logic            flush_i;
  logic [XLEN-1:0] result_o;
  logic            ready_o;
  logic            reg_we_o;
  logic [4:0]      reg_waddr_o;
  logic            busy_o;
  logic            hold_req_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    input  result_o, ready_o, reg_we_o, reg_waddr_o, busy_o, hold_req_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    output result_o, ready_o, reg_we_o, reg_waddr_o, busy_o, hold_req_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: one restoring-division step
// per cycle, holds the pipeline while busy, writes rd back through its own
// pulse, and aborts on a pipeline flush.
// Optional build macro DIV_SEQ_FAST_ZERO_EN: a zero divisor skips the
// iteration loop and goes from START straight to the result cycle.
module div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_FIN} state_t;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic              accept;
  logic [1:0]        op_q;          // funct3[1:0]: bit0 = unsigned, bit1 = remainder
  logic [XLEN-1:0]   a_q, b_q;      // raw operands as issued
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   quo_q, rem_q, dvs_q;
  logic              neg_q, neg_r;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;

  logic              is_signed, is_rem;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_nxt, quo_nxt;
  logic [XLEN-1:0]   q_fix, r_fix, res_fin;

  assign is_signed = ~op_q[0];
  assign is_rem    = op_q[1];
  assign accept    = bus.start_i && (state_q == S_IDLE) && !bus.flush_i && bus.op_i[2];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state: flush wins everywhere outside IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: begin
        if (bus.flush_i) state_d = S_IDLE;
`ifdef DIV_SEQ_FAST_ZERO_EN
        else if (b_q == '0) state_d = S_FIN;
`else
`endif
        else state_d = S_CALC;
      end
      S_CALC: begin
        if (bus.flush_i)                         state_d = S_IDLE;
        else if (cnt_q == CNT_W'(XLEN-1))        state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // operand magnitudes for the unsigned core
  always_comb begin
    abs_a = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
    abs_b = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;
  end

  // one restoring step: shift rem:quo left, trial-subtract at XLEN+1 bits
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    rem_nxt = rem_sh[XLEN-1:0];
    if (rem_sh >= {1'b0, dvs_q}) begin
      rem_nxt    = rem_sh[XLEN-1:0] - dvs_q;
      quo_nxt[0] = 1'b1;
    end
  end

  // sign fix, then divide-by-zero and overflow overrides
  always_comb begin
    q_fix = neg_q ? -quo_q : quo_q;
    r_fix = neg_r ? -rem_q : rem_q;
    if (b_q == '0) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (is_signed && (a_q == SMIN) && (b_q == '1)) begin
      q_fix = SMIN;
      r_fix = '0;
    end
    res_fin = is_rem ? r_fix : q_fix;
  end

  // datapath: latch request, set up magnitudes, iterate, retire result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q <= bus.op_i[1:0];
          a_q  <= bus.dividend_i;
          b_q  <= bus.divisor_i;
          rd_q <= bus.reg_waddr_i;
        end
        S_START: begin
          quo_q <= abs_a;
          dvs_q <= abs_b;
          rem_q <= '0;
          neg_q <= is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          neg_r <= is_signed & a_q[XLEN-1];
          cnt_q <= '0;
        end
        S_CALC: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_FIN: if (!bus.flush_i) result_q <= res_fin;
        default: ;
      endcase
    end
  end

  // outputs: result cycle pulses are gated by a coincident flush so that an
  // aborted divide neither writes rd nor disturbs the held result
  always_comb begin
    bus.ready_o     = (state_q == S_FIN) && !bus.flush_i;
    bus.reg_we_o    = bus.ready_o;
    bus.reg_waddr_o = rd_q;
    bus.result_o    = bus.ready_o ? res_fin : result_q;
    bus.busy_o      = (state_q != S_IDLE);
    bus.hold_req_o  = accept || (state_q == S_START) || (state_q == S_CALC);
  end

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq against an arithmetic reference.
module tb_div_seq;
  localparam int XLEN = 32;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  div_seq_if #(.XLEN(XLEN)) bus ();

  div_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // RISC-V M-extension semantics written directly with SV arithmetic
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == SMIN) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b100:  ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? SMIN  : 32'($signed(a) / $signed(b));
      3'b101:  ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  ref_div = (b == 0) ? a             : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: ref_div = (b == 0) ? a             : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_SEQ_FAST_ZERO_EN
    ref_lat = (b == 0) ? 2 : XLEN + 2;
`else
    ref_lat = XLEN + 2;
`endif
  endfunction

  // Entered just after a negedge; drives start in cycle 0 and returns at the
  // same point of cycle lat+1, so consecutive calls are back-to-back.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp, res;
    logic [4:0]  wa;
    int lat, rdy_cyc, rdy_n, last_hold, busy_lo, we_mis;
    exp = ref_div(op, a, b);
    lat = ref_lat(b);
    bus.start_i = 1'b1; bus.op_i = op; bus.dividend_i = a; bus.divisor_i = b; bus.reg_waddr_i = rd;
    #1 chk("hold_cycle0", 32'(bus.hold_req_o), 32'd1);
    rdy_n = 0; rdy_cyc = -1; last_hold = 0; busy_lo = -1; we_mis = 0; res = '0; wa = '0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      bus.start_i = (c < 6);          // keep requesting while busy: must be ignored
      bus.op_i = 3'b101;
      #1;
      if (bus.ready_o) begin rdy_n++; rdy_cyc = c; res = bus.result_o; wa = bus.reg_waddr_o; end
      if (bus.ready_o !== bus.reg_we_o) we_mis++;
      if (bus.hold_req_o) last_hold = c;
      if (!bus.busy_o && busy_lo < 0) busy_lo = c;
    end
    bus.start_i = 1'b0;
    chk("ready_cycle", 32'(rdy_cyc), 32'(lat));
    chk("ready_count", 32'(rdy_n), 32'd1);
    chk($sformatf("result op=%b a=%h b=%h", op, a, b), res, exp);
    chk("reg_waddr", {27'd0, wa}, {27'd0, rd});
    chk("we_eq_ready", 32'(we_mis), 32'd0);
    chk("hold_last", 32'(last_hold), 32'(lat - 1));
    chk("busy_fall", 32'(busy_lo), 32'(lat + 1));
    chk("result_held", bus.result_o, exp);
  endtask

  // flush in cycle k; checks abort, then returns in cycle k+1 (IDLE)
  task automatic run_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
    logic [31:0] prev;
    int rdy_n;
    prev = bus.result_o;
    rdy_n = 0;
    bus.start_i = 1'b1; bus.op_i = op; bus.dividend_i = a; bus.divisor_i = b; bus.reg_waddr_i = 5'd9;
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = (c == k);
      #1;
      if (bus.ready_o || bus.reg_we_o) rdy_n++;
    end
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    chk($sformatf("flush%0d_no_ready", k), 32'(rdy_n), 32'd0);
    chk($sformatf("flush%0d_idle", k), 32'(bus.busy_o), 32'd0);
    chk($sformatf("flush%0d_result", k), bus.result_o, prev);
  endtask

  initial begin
    int r, seen;
    logic [2:0]  op;
    logic [31:0] a, b;
    bus.start_i = 0; bus.op_i = 0; bus.dividend_i = 0; bus.divisor_i = 0;
    bus.reg_waddr_i = 0; bus.flush_i = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready",  32'(bus.ready_o), 32'd0);
    chk("rst_we",     32'(bus.reg_we_o), 32'd0);
    chk("rst_busy",   32'(bus.busy_o), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_waddr",  {27'd0, bus.reg_waddr_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // directed cases
    run_op(3'b101, 32'd100, 32'd7, 5'd5);
    run_op(3'b110, -32'sd7, 32'd2, 5'd1);
    run_op(3'b100, -32'sd7, 32'd2, 5'd2);
    run_op(3'b100, SMIN, 32'hFFFF_FFFF, 5'd3);
    run_op(3'b110, SMIN, 32'hFFFF_FFFF, 5'd4);
    run_op(3'b100, 32'd5, 32'd0, 5'd6);
    run_op(3'b111, 32'd9, 32'd0, 5'd7);
    run_op(3'b110, -32'sd9, 32'd0, 5'd8);
    run_op(3'b111, 32'hFFFF_FFFF, 32'd1, 5'd31);

    // flush mid-operation, then a new start accepted right away
    run_flush(3'b101, 32'd1000, 32'd3, 10);
    run_op(3'b101, 32'd1000, 32'd3, 5'd10);
    // flush coinciding with the result cycle
    run_flush(3'b100, 32'd77, 32'd5, XLEN + 2);
    // flush and start together in IDLE: ignored
    bus.start_i = 1; bus.flush_i = 1; bus.op_i = 3'b101;
    @(negedge clk); bus.start_i = 0; bus.flush_i = 0; #1;
    chk("flush_start_ignored", 32'(bus.busy_o), 32'd0);
    // op_i[2]==0 is not a divide
    bus.start_i = 1; bus.op_i = 3'b010;
    #1 chk("op010_no_hold", 32'(bus.hold_req_o), 32'd0);
    @(negedge clk); bus.start_i = 0; #1;
    chk("op010_no_accept", 32'(bus.busy_o), 32'd0);

    // randomized
    for (int i = 0; i < 24; i++) begin
      r  = $urandom_range(0, 9);
      op = {1'b1, 2'($urandom)};
      a  = $urandom;
      b  = $urandom;
      if (r == 0) b = 0;
      else if (r == 1) begin a = SMIN; b = 32'hFFFF_FFFF; end
      else if (r < 5) b = $urandom_range(1, 15);
      else if (r == 5) b = -32'($urandom_range(1, 15));
      run_op(op, a, b, 5'($urandom));
    end

    // reset in cycle 20 of a divide, with a stray op=010 start while busy
    bus.start_i = 1; bus.op_i = 3'b101; bus.dividend_i = 32'd50; bus.divisor_i = 32'd3; bus.reg_waddr_i = 5'd12;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.op_i = 3'b010;
      bus.start_i = (c < 20);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_ready",  32'(bus.ready_o), 32'd0);
    chk("mid_rst_we",     32'(bus.reg_we_o), 32'd0);
    chk("mid_rst_busy",   32'(bus.busy_o), 32'd0);
    chk("mid_rst_hold",   32'(bus.hold_req_o), 32'd0);
    chk("mid_rst_result", bus.result_o, 32'd0);
    chk("mid_rst_waddr",  {27'd0, bus.reg_waddr_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (bus.ready_o || bus.reg_we_o || bus.busy_o) seen++;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
